// File: rtl/trans_receive_if.sv
// Serial-receive bundle: the serial line into the receiver, and the parallel
// payload with its status strobes back out to the consumer.
interface trans_receive_if #(
  parameter int DATA_W = 55
);
  logic              S_Data;
  logic [DATA_W-1:0] RX_Data;
  logic              valid;
  logic              busy;
  logic              frame_err;

  modport master (output S_Data, input RX_Data, valid, busy, frame_err);
  modport slave  (input S_Data, output RX_Data, valid, busy, frame_err);
endinterface

// File: rtl/trans_receive.sv
// Token-ring frame receiver: hunts for a start pattern on the serial line,
// shifts in an MSB-first payload, then samples one gap bit for framing errors.
module trans_receive #(
  parameter int               SEQ_W     = 6,
  parameter logic [SEQ_W-1:0] START_SEQ = 6'b011111,
  parameter int               DATA_W    = 55
) (
  input  logic            clk,
  input  logic            rst,
  trans_receive_if.slave  rx
);
  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RECV  = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [5:0] LAST = 6'(DATA_W - 1);

  state_t            state_q;
  logic [SEQ_W-1:0]  hist_q;
  logic [SEQ_W-1:0]  hist_d;
  logic [DATA_W-2:0] shreg_q;
  logic [5:0]        cnt_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_q;

  assign hist_d = {hist_q[SEQ_W-2:0], rx.S_Data};

  // Payload shifter is pure data; a new frame always overwrites every bit.
  always_ff @(posedge clk) begin
    if (state_q == RECV) begin
      shreg_q <= {shreg_q[DATA_W-3:0], rx.S_Data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      hist_q    <= '1;
      cnt_q     <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        HUNT: begin
          hist_q <= hist_d;
          if (hist_d == START_SEQ) begin
            state_q <= RECV;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RECV: begin
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST) begin
            rx_data_q <= {shreg_q, rx.S_Data};
            valid_q   <= 1'b1;
            state_q   <= GUARD;
          end
        end
        GUARD: begin
          // The gap bit stays in history so it can open the next start pattern.
          err_q   <= rx.S_Data;
          hist_q  <= {{(SEQ_W-1){1'b1}}, rx.S_Data};
          state_q <= HUNT;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= HUNT;
          hist_q  <= '1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.RX_Data   = rx_data_q;
  assign rx.valid     = valid_q;
  assign rx.busy      = busy_q;
  assign rx.frame_err = err_q;
endmodule

// File: tb/tb_trans_receive.sv
// Scoreboard bench for trans_receive: a stream-level frame model predicts
// valid/frame_err events and per-cycle busy/RX_Data; a monitor checks them.
module tb_trans_receive;
  localparam int DW = 55;

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [DW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trans_receive_if #(.DATA_W(DW)) bus ();

  trans_receive #(.SEQ_W(6), .START_SEQ(6'b011111), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus)
  );

  bit            stream[$];
  bit            exp_busy[$];
  logic [DW-1:0] exp_rx[$];
  ev_t           exp_q[$];
  int            drv_k = 0;
  bit            seg_on = 1'b0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(string name, int cyc, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at bit %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic add_bits(logic [DW-1:0] v, int n);
    for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
  endtask

  task automatic add_start();
    add_bits(55'b011111, 6);
  endtask

  // Frame model: a start pattern must lie wholly at or after the point where
  // hunting resumed (reset, or the gap bit of the previous frame).
  task automatic build_model();
    int n, hs, k, t0;
    logic [DW-1:0] rxv, p;
    ev_t e;
    n = stream.size();
    exp_busy = {};
    exp_rx = {};
    exp_q = {};
    for (int j = 0; j < n; j++) begin
      exp_busy.push_back(1'b0);
      exp_rx.push_back('0);
    end
    hs = 0;
    k = 5;
    rxv = '0;
    while (k < n) begin
      if (k - 5 >= hs && !stream[k-5] && stream[k-4] && stream[k-3] &&
          stream[k-2] && stream[k-1] && stream[k]) begin
        t0 = k;
        for (int j = t0; j <= t0 + 55 && j < n; j++) exp_busy[j] = 1'b1;
        if (t0 + 55 >= n) break;
        p = '0;
        for (int j = 1; j <= 55; j++) p[DW-j] = stream[t0+j];
        e.cyc = t0 + 55; e.is_err = 1'b0; e.data = p;
        exp_q.push_back(e);
        for (int j = t0 + 55; j < n; j++) exp_rx[j] = p;
        if (t0 + 56 >= n) break;
        if (stream[t0+56]) begin
          e.cyc = t0 + 56; e.is_err = 1'b1; e.data = p;
          exp_q.push_back(e);
        end
        hs = t0 + 56;
        k = hs + 5;
      end else begin
        k++;
      end
    end
  endtask

  task automatic run_segment(string name);
    int n;
    build_model();
    n = stream.size();
    rst = 1'b1;
    bus.S_Data = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.S_Data = stream[0];
    drv_k = 0;
    seg_on = 1'b1;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      bus.S_Data = stream[i];
      drv_k = i;
    end
    @(negedge clk);
    seg_on = 1'b0;
    bus.S_Data = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing events: got %0d pending want 0", name, exp_q.size());
    end
    stream = {};
  endtask

  // Monitor: samples 2 time units after each sampling edge.
  initial begin
    int k;
    bit v_exp, e_exp;
    forever begin
      @(posedge clk);
      #2;
      if (seg_on) begin
        k = drv_k;
        chk("busy", k, DW'(bus.busy), DW'(exp_busy[k]));
        chk("RX_Data", k, bus.RX_Data, exp_rx[k]);
        v_exp = exp_q.size() > 0 && exp_q[0].cyc == k && !exp_q[0].is_err;
        chk("valid", k, DW'(bus.valid), DW'(v_exp));
        if (v_exp) begin
          chk("valid_data", k, bus.RX_Data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        e_exp = exp_q.size() > 0 && exp_q[0].cyc == k && exp_q[0].is_err;
        chk("frame_err", k, DW'(bus.frame_err), DW'(e_exp));
        if (e_exp) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [63:0] r;
    logic [DW-1:0] p;
    bus.S_Data = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.RX_Data !== '0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rx=%h v=%b b=%b e=%b want all zero",
               bus.RX_Data, bus.valid, bus.busy, bus.frame_err);
    end

    add_bits('0, 20);
    run_segment("idle");

    add_bits('0, 3); add_start(); add_bits(55'h5_AAAA_AAAA_AAAA_A, 55); add_bits('0, 4);
    run_segment("single");

    add_bits('0, 2); add_start(); add_bits(55'h0000_0000_0000_1F, 55);
    add_bits('0, 2); add_start(); add_bits(55'h7_FFFF_FFFF_FFFF_F, 55); add_bits('0, 3);
    run_segment("back_to_back");

    add_start(); add_bits(55'h12_3456_789A_BCDE, 55); add_bits(55'b1, 1); add_bits('0, 2);
    add_start(); add_bits(55'h3_1415_9265_3589_7, 55); add_bits('0, 3);
    run_segment("frame_err");

    add_start(); add_bits(55'h2_DEAD_BEEF_CAFE_5 >> 25, 30);
    run_segment("aborted");
    add_bits('0, 5); add_start(); add_bits(55'h1, 55); add_bits('0, 3);
    run_segment("after_abort");

    add_bits(55'b1101111011111, 13); add_bits(55'h6_0F0F_1234_5678_9, 55); add_bits('0, 3);
    run_segment("noise");

    // Tightest spacing: gap bit reused as the leading 0 of the next pattern.
    add_start(); add_bits(55'h0_0000_0000_00C3_3, 55);
    add_bits('0, 1); add_bits(55'b11111, 5); add_bits(55'h5_5555_0000_FFFF_1, 55); add_bits('0, 3);
    run_segment("tight");

    for (int f = 0; f < 6; f++) begin
      int nz = $urandom_range(8);
      for (int i = 0; i < nz; i++) stream.push_back(bit'($urandom_range(1)));
      add_bits('0, 1);
      add_start();
      r = {$urandom(), $urandom()};
      p = r[DW-1:0];
      add_bits(p, 55);
      stream.push_back(bit'($urandom_range(3) == 0));
      add_bits('0, $urandom_range(1, 3));
    end
    add_bits('0, 3);
    run_segment("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
